// File: rtl/watch_pkg.sv
// Shared field limits, widths and helpers for the watch timekeeper.
package watch_pkg;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;

  // Net adjust request for one field after inc/dec cancellation
  typedef struct packed {
    logic inc;
    logic dec;
  } adj_t;

  function automatic adj_t resolve_adj(input logic up, input logic dn);
    adj_t a;
    a.inc = up & ~dn;
    a.dec = dn & ~up;
    return a;
  endfunction

  // Internal 0..23 hour to display hour; 12-hour mode maps 0->12, 13..23->1..11
  function automatic logic [5:0] disp_hour(input logic [HOUR_W-1:0] h, input logic m12);
    if (!m12)            return {1'b0, h};
    if (h == '0)         return 6'd12;
    if (h > 5'd12)       return {1'b0, h - 5'd12};
    return {1'b0, h};
  endfunction
endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) field counter: a carrying tick step, then a non-carrying adjust step.
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic [W-1:0] tick_value,
  output logic         carry
);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] nxt;

  always_comb begin
    tick_value = value;
    if (tick) tick_value = (value == MAXV) ? '0 : value + W'(1);
    // adjustment lands on the post-tick value and never carries
    nxt = tick_value;
    if (inc && !dec)      nxt = (tick_value == MAXV) ? '0 : tick_value + W'(1);
    else if (dec && !inc) nxt = (tick_value == '0) ? MAXV : tick_value - W'(1);
    if (clr) nxt = '0;
  end

  assign carry = tick & (value == MAXV);

  always_ff @(posedge clk) begin
    if (reset) value <= '0;
    else       value <= nxt;
  end
endmodule

// File: rtl/watch_timekeeper.sv
// Digital watch: prescaled seconds/minutes/hours, edge-detected set buttons,
// 12/24-hour display and a tick-triggered alarm with timed ring.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int RING_SECS     = 30
) (
  input  logic              Clk_1sec,
  input  logic              reset,
  input  logic              clock_enable,
  input  logic              min_inc,
  input  logic              min_dec,
  input  logic              hour_inc,
  input  logic              hour_dec,
  input  logic              mode_12h,
  input  logic              alarm_load,
  input  logic [MIN_W-1:0]  alarm_min_in,
  input  logic [HOUR_W-1:0] alarm_hour_in,
  input  logic              alarm_en,
  input  logic              alarm_ack,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [5:0]        hours,
  output logic              pm,
  output logic              sec_tick,
  output logic              alarm_ring
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    RING_LD  = 8'(RING_SECS);

  logic [PW-1:0]     presc;
  logic              tick;
  logic [3:0]        btn, btn_q, rise;
  adj_t              min_adj, hour_adj;
  logic              min_touch;
  logic [SEC_W-1:0]  sec_tv;
  logic [MIN_W-1:0]  min_tv;
  logic [HOUR_W-1:0] hour_int, hour_tv;
  logic              sec_carry, min_carry, day_wrap_unused;
  logic [MIN_W-1:0]  alarm_min;
  logic [HOUR_W-1:0] alarm_hour;
  logic [7:0]        ring_cnt;
  logic              trig;

  assign tick = clock_enable & (presc == PRE_LAST);

  // history resets high so a button held through reset is not seen as a press
  assign btn       = {hour_dec, hour_inc, min_dec, min_inc};
  assign rise      = btn & ~btn_q;
  assign min_adj   = resolve_adj(rise[0], rise[1]);
  assign hour_adj  = resolve_adj(rise[2], rise[3]);
  assign min_touch = min_adj.inc | min_adj.dec;

  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      btn_q    <= '1;
      presc    <= '0;
      sec_tick <= 1'b0;
    end else begin
      btn_q    <= btn;
      sec_tick <= tick;
      if (min_touch)         presc <= '0;
      else if (clock_enable) presc <= tick ? '0 : presc + PW'(1);
    end
  end

  wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(Clk_1sec), .reset(reset), .tick(tick), .inc(1'b0), .dec(1'b0),
    .clr(min_touch), .value(seconds), .tick_value(sec_tv), .carry(sec_carry)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(Clk_1sec), .reset(reset), .tick(sec_carry), .inc(min_adj.inc), .dec(min_adj.dec),
    .clr(1'b0), .value(minutes), .tick_value(min_tv), .carry(min_carry)
  );

  wrap_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk(Clk_1sec), .reset(reset), .tick(min_carry), .inc(hour_adj.inc), .dec(hour_adj.dec),
    .clr(1'b0), .value(hour_int), .tick_value(hour_tv), .carry(day_wrap_unused)
  );

  assign hours = disp_hour(hour_int, mode_12h);
  assign pm    = (hour_int >= 5'd12);

  // only the tick-advanced time can match, so setting the clock onto the alarm stays silent
  assign trig = tick & alarm_en & (sec_tv == '0) & (min_tv == alarm_min) & (hour_tv == alarm_hour);

  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      alarm_min  <= '0;
      alarm_hour <= '0;
    end else if (alarm_load) begin
      alarm_min  <= (alarm_min_in > 6'(MIN_MAX))   ? 6'(MIN_MAX)  : alarm_min_in;
      alarm_hour <= (alarm_hour_in > 5'(HOUR_MAX)) ? 5'(HOUR_MAX) : alarm_hour_in;
    end
  end

  always_ff @(posedge Clk_1sec) begin
    if (reset || alarm_ack || !alarm_en) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (trig) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= RING_LD;
    end else if (alarm_ring) begin
      if (ring_cnt == '0) alarm_ring <= 1'b0;
      else if (tick)      ring_cnt   <= ring_cnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper: seconds-of-day reference model checked every cycle,
// a table of set-button vectors, directed alarm/reset sequences and random stimulus.
module tb_watch_timekeeper;
  localparam int TPS  = 4;
  localparam int RING = 3;

  logic       clk = 1'b0;
  logic       reset, clock_enable, min_inc, min_dec, hour_inc, hour_dec, mode_12h;
  logic       alarm_load, alarm_en, alarm_ack;
  logic [5:0] alarm_min_in;
  logic [4:0] alarm_hour_in;
  logic [5:0] seconds, minutes, hours;
  logic       pm, sec_tick, alarm_ring;

  int n_err = 0;
  int n_chk = 0;
  int cyc_n = 0;

  // reference model state
  int m_t, m_presc, m_am, m_ah, m_cnt;
  bit m_ring, m_tick;
  bit prev[4];

  watch_timekeeper #(.TICKS_PER_SEC(TPS), .RING_SECS(RING)) dut (
    .Clk_1sec(clk), .reset(reset), .clock_enable(clock_enable),
    .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec),
    .mode_12h(mode_12h), .alarm_load(alarm_load), .alarm_min_in(alarm_min_in),
    .alarm_hour_in(alarm_hour_in), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .seconds(seconds), .minutes(minutes), .hours(hours), .pm(pm),
    .sec_tick(sec_tick), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit b[4];
    int r[4];
    int h, m, s, net;
    bit tk, trig;
    if (reset) begin
      m_t = 0; m_presc = 0; m_am = 0; m_ah = 0; m_cnt = 0; m_ring = 0; m_tick = 0;
      for (int i = 0; i < 4; i++) prev[i] = 1;
      return;
    end
    b = '{min_inc, min_dec, hour_inc, hour_dec};
    for (int i = 0; i < 4; i++) begin
      r[i] = (b[i] && !prev[i]) ? 1 : 0;
      prev[i] = b[i];
    end
    tk = clock_enable && (m_presc == TPS - 1);
    if (clock_enable) m_presc = tk ? 0 : m_presc + 1;
    if (tk) m_t = (m_t + 1) % 86400;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    trig = tk && alarm_en && s == 0 && m == m_am && h == m_ah;
    net = r[0] - r[1];
    if (net != 0) begin m = (m + net + 60) % 60; s = 0; m_presc = 0; end
    net = r[2] - r[3];
    h = (h + net + 24) % 24;
    m_t = h * 3600 + m * 60 + s;
    if (alarm_ack || !alarm_en) begin m_ring = 0; m_cnt = 0; end
    else if (trig) begin m_ring = 1; m_cnt = RING; end
    else if (m_ring) begin
      if (m_cnt == 0) m_ring = 0;
      else if (tk) m_cnt--;
    end
    if (alarm_load) begin
      m_am = (alarm_min_in > 59) ? 59 : int'(alarm_min_in);
      m_ah = (alarm_hour_in > 23) ? 23 : int'(alarm_hour_in);
    end
    m_tick = tk;
  endtask

  task automatic check_model();
    int h, m, s, eh;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    eh = mode_12h ? ((h + 11) % 12) + 1 : h;
    n_chk++;
    if (int'(seconds) != s || int'(minutes) != m || int'(hours) != eh || pm != (h >= 12) ||
        sec_tick != m_tick || alarm_ring != m_ring) begin
      n_err++;
      $display("FAIL model cyc %0d: got %0d:%0d:%0d disp_h=%0d pm=%0b tick=%0b ring=%0b, want %0d:%0d:%0d disp_h=%0d pm=%0b tick=%0b ring=%0b",
               cyc_n, hours, minutes, seconds, hours, pm, sec_tick, alarm_ring,
               h, m, s, eh, h >= 12, m_tick, m_ring);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    #1;
    check_model();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic press(input int which);
    case (which)
      0: min_inc = 1; 1: min_dec = 1; 2: hour_inc = 1; default: hour_dec = 1;
    endcase
    cyc();
    min_inc = 0; min_dec = 0; hour_inc = 0; hour_dec = 0;
    cyc();
  endtask

  // step 07:30 back to 07:29:00, run 59 seconds, then wait for the ring
  task automatic run_to_ring(output bit ok);
    clock_enable = 0;
    press(1);
    clock_enable = 1;
    repeat (59 * TPS) cyc();
    chk("pre_alarm_time", int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds), 7 * 3600 + 29 * 60 + 59);
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      cyc();
      ok = alarm_ring;
    end
    chk("ring_rise", int'(ok), 1);
  endtask

  typedef struct {
    bit mi, md, hi, hd, mode;
    int emin, ehrs;
    bit epm;
  } vec_t;

  initial begin
    vec_t tbl[13];
    bit ok;
    int n, changes;
    logic [5:0] last_min;

    reset = 1; clock_enable = 0; min_inc = 0; min_dec = 0; hour_inc = 0; hour_dec = 0;
    mode_12h = 0; alarm_load = 0; alarm_min_in = 0; alarm_hour_in = 0; alarm_en = 0; alarm_ack = 0;
    #2;
    repeat (2) cyc();
    chk("rst_sec", seconds, 0); chk("rst_min", minutes, 0); chk("rst_hrs", hours, 0);
    chk("rst_pm", pm, 0); chk("rst_tick", sec_tick, 0); chk("rst_ring", alarm_ring, 0);

    // prescaler: first tick on the 4th enabled cycle
    reset = 0; clock_enable = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("tick_cyc%0d", i), sec_tick, (i == 4) ? 1 : 0);
    end
    chk("sec_after_4", seconds, 1);
    clock_enable = 0;
    repeat (10) cyc();
    chk("sec_frozen", seconds, 1);
    chk("tick_frozen", sec_tick, 0);

    // set-button vectors, time frozen
    tbl[0]  = '{0,0,0,1,0,  0, 23, 1};
    tbl[1]  = '{0,0,0,0,1,  0, 11, 1};
    tbl[2]  = '{0,0,1,0,1,  0, 12, 0};
    tbl[3]  = '{0,0,1,0,0,  0,  0, 0};
    tbl[4]  = '{0,0,0,0,0,  0,  0, 0};
    tbl[5]  = '{0,1,0,0,0, 59,  0, 0};
    tbl[6]  = '{1,0,0,0,0,  0,  0, 0};
    tbl[7]  = '{0,0,0,0,0,  0,  0, 0};
    tbl[8]  = '{1,1,0,0,0,  0,  0, 0};
    tbl[9]  = '{0,0,0,0,0,  0,  0, 0};
    tbl[10] = '{0,0,1,1,0,  0,  0, 0};
    tbl[11] = '{0,0,0,0,0,  0,  0, 0};
    tbl[12] = '{0,0,1,0,1,  0,  1, 0};
    foreach (tbl[i]) begin
      min_inc = tbl[i].mi; min_dec = tbl[i].md; hour_inc = tbl[i].hi; hour_dec = tbl[i].hd;
      mode_12h = tbl[i].mode;
      cyc();
      chk($sformatf("vec%0d_min", i), minutes, tbl[i].emin);
      chk($sformatf("vec%0d_hrs", i), hours, tbl[i].ehrs);
      chk($sformatf("vec%0d_pm", i), pm, int'(tbl[i].epm));
    end
    chk("min_adj_clears_sec", seconds, 0);
    min_inc = 0; hour_inc = 0; mode_12h = 0;
    cyc();

    // held min_inc at 59 steps once, no carry into hours
    press(1);
    chk("min_at_59", minutes, 59);
    min_inc = 1; changes = 0; last_min = minutes;
    repeat (20) begin
      cyc();
      if (minutes != last_min) changes++;
      last_min = minutes;
    end
    min_inc = 0;
    cyc();
    chk("held_changes", changes, 1);
    chk("held_min", minutes, 0);
    chk("held_hrs", hours, 1);

    // 23:59:58 rolls to 00:00:00
    press(3); press(3); press(1);
    clock_enable = 1;
    repeat (58 * TPS) cyc();
    chk("pre_roll_hms", int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds), 86398);
    chk("pre_roll_pm", pm, 1);
    repeat (2 * TPS) cyc();
    chk("roll_hms", int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds), 0);
    chk("roll_pm", pm, 0);
    clock_enable = 0; mode_12h = 1;
    cyc();
    chk("roll_12h", hours, 12);
    mode_12h = 0;

    // alarm 07:30, ring for 3 ticks
    alarm_load = 1; alarm_min_in = 30; alarm_hour_in = 7;
    cyc();
    alarm_load = 0; alarm_en = 1;
    repeat (7) press(2);
    repeat (30) press(0);
    chk("set_to_alarm_no_ring", alarm_ring, 0);
    run_to_ring(ok);
    chk("ring_time", int'(minutes) * 60 + int'(seconds), 30 * 60);
    n = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      if (!alarm_ring) ok = 1;
      else if (sec_tick) n++;
    end
    chk("ring_ticks", n, RING);
    chk("ring_fell", int'(ok), 1);

    // ack after the first tick of a ring
    run_to_ring(ok);
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      cyc();
      ok = sec_tick;
    end
    chk("ack_tick_seen", int'(ok), 1);
    alarm_ack = 1;
    cyc();
    chk("ack_clears", alarm_ring, 0);
    alarm_ack = 0;
    repeat (3) cyc();
    chk("ack_stays", alarm_ring, 0);

    // reset mid-ring with buttons held
    run_to_ring(ok);
    reset = 1; min_inc = 1; hour_inc = 1;
    cyc();
    chk("rr_sec", seconds, 0); chk("rr_min", minutes, 0); chk("rr_hrs", hours, 0);
    chk("rr_pm", pm, 0); chk("rr_tick", sec_tick, 0); chk("rr_ring", alarm_ring, 0);
    reset = 0; clock_enable = 0;
    repeat (3) cyc();
    chk("rr_held_min", minutes, 0);
    chk("rr_held_hrs", hours, 0);
    min_inc = 0; hour_inc = 0;
    cyc();

    // random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      clock_enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) min_inc  = ~min_inc;
      if ($urandom_range(0, 3) == 0) min_dec  = ~min_dec;
      if ($urandom_range(0, 3) == 0) hour_inc = ~hour_inc;
      if ($urandom_range(0, 3) == 0) hour_dec = ~hour_dec;
      mode_12h      = 1'($urandom_range(0, 1));
      alarm_load    = ($urandom_range(0, 15) == 0);
      alarm_min_in  = 6'($urandom_range(0, 63));
      alarm_hour_in = 5'($urandom_range(0, 31));
      alarm_en      = ($urandom_range(0, 15) != 0);
      alarm_ack     = ($urandom_range(0, 31) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/watch_timekeeper.md
WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1: Clk_1sec cycles per second tick; legal range 1..2^24.
REQ-002 Parameter RING_SECS, default 30: alarm ring duration in seconds; legal range 1..255.
REQ-003 Clk_1sec  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clock_enable  in  1  1 = timekeeping runs; 0 = time frozen, adjustment still allowed.
REQ-006 min_inc, min_dec, hour_inc, hour_dec  in  1 each  level adjust buttons, synchronous to Clk_1sec.
REQ-007 mode_12h  in  1  0 = 24-hour display; 1 = 12-hour display.
REQ-008 alarm_load  in  1  one-cycle strobe capturing alarm_min_in/alarm_hour_in.
REQ-009 alarm_min_in  in  6  alarm minute, 0..59; alarm_hour_in  in  5  alarm hour, 0..23, always 24-hour.
REQ-010 alarm_en  in  1  arms the alarm; alarm_ack  in  1  silences ringing.
REQ-011 seconds  out  6  0..59; minutes  out  6  0..59.
REQ-012 hours  out  6  display hour: 0..23 when mode_12h=0; 1..12 when mode_12h=1.
REQ-013 pm  out  1  1 when internal hour is 12..23, in both modes.
REQ-014 sec_tick  out  1  one-cycle pulse on each counted second.
REQ-015 alarm_ring  out  1  high while the alarm rings.

Function
REQ-016 Prescaler counts 0..TICKS_PER_SEC-1 while clock_enable=1, wraps to 0, and raises sec_tick in the wrap cycle; TICKS_PER_SEC=1 ticks every enabled cycle.
REQ-017 With clock_enable=0 the prescaler holds its value and sec_tick stays 0.
REQ-018 On a tick: seconds increments; 59->0 carries into minutes; minutes 59->0 carries into the 0..23 internal hour; 23->0 wraps with no further carry.
REQ-019 Each adjust input is edge-detected; exactly one adjustment per 0->1 transition, whatever the hold time.
REQ-020 min_inc/min_dec step minutes +1/-1 modulo 60, with no carry into hours; hour_inc/hour_dec step the internal hour +1/-1 modulo 24.
REQ-021 An adjustment to minutes clears seconds and the prescaler to 0.
REQ-022 Rising edges of inc and dec on the same field in the same cycle cancel: that field is unchanged.
REQ-023 A tick and an adjust edge in the same cycle: tick and carries are applied first; the adjustment is applied to the result in the same cycle.
REQ-024 12-hour display mapping from internal hour: 0->12, 1..12->same, 13..23->minus 12; combinational from registered state, so a mode_12h change is visible in the same cycle.
REQ-025 alarm_load writes both alarm registers in one cycle; out-of-range values are saturated (minute to 59, hour to 23).
REQ-026 Alarm trigger: in a tick cycle where the post-tick time is hour=alarm_hour, minutes=alarm_min, seconds=0, and alarm_en=1, alarm_ring goes 1 on the next cycle and the ring counter loads RING_SECS.
REQ-027 While ringing, each tick decrements the ring counter; alarm_ring falls in the cycle after the counter reaches 0.
REQ-028 alarm_ack=1 or alarm_en=0 clears alarm_ring and the ring counter on the next edge, with priority over a simultaneous trigger.
REQ-029 A trigger reached through an adjustment instead of a tick does not ring.

Reset
REQ-030 reset=1 sets seconds, minutes, internal hour, prescaler, ring counter, alarm_min and alarm_hour to 0, and alarm_ring and sec_tick to 0.
REQ-031 Reset sets the edge-detect history registers to 1, so a button held through reset does not adjust.
REQ-032 reset has priority over every other input, including during an active ring or a mid-count prescaler.

Structure
REQ-033 The shared package watch_pkg holds SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23 and the field widths (6/6/5).
REQ-034 One sub-module, wrap_counter, is instantiated for seconds, minutes and hours: parameter MAX; inputs inc, dec, clr; outputs value and carry.

Verification
REQ-035 TICKS_PER_SEC=4, clock_enable=1 from reset: first sec_tick on cycle 4; seconds=1 after 4 cycles; clock_enable=0 for 10 cycles leaves seconds unchanged.
REQ-036 Preset 23:59:58, two ticks: time=00:00:00; pm goes 1->0; with mode_12h=1, hours=12.
REQ-037 min_inc held high for 20 cycles at minutes=59: minutes=0 exactly once and hours unchanged; min_inc and min_dec rising together: minutes unchanged.
REQ-038 hour_dec at internal hour 0 gives 23; mode_12h=1 shows hours=11, pm=1.
REQ-039 Alarm 07:30, alarm_en=1, RING_SECS=3, time 07:29:59 plus one tick: alarm_ring=1 for exactly 3 ticks; a repeat run with alarm_ack at tick 1 clears alarm_ring on the next cycle.
REQ-040 reset asserted mid-ring with a button held: all outputs 0 on the next edge; no adjustment occurs after reset releases.
